// File: rtl/dostring_pkg.sv
`default_nettype none
// ============================================================================
// Module  : dostring_pkg
// Purpose : Shared definitions for the dostring LED-string blocks: pattern
//           mode codes, pattern-source state encodings, APA102 word header
//           and field offsets, plus a word-assembly helper.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package dostring_pkg;

  typedef enum logic [1:0] {
    MODE_CHASE = 2'd0,
    MODE_SOLID = 2'd1,
    MODE_RAMP  = 2'd2,
    MODE_OFF   = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam logic [2:0] APA102_HDR = 3'b111;

  // Bit offsets inside a 32-bit APA102 LED word. The colour offsets also
  // describe the packing of the 24-bit BGR triple (R at the bottom).
  localparam int WORD_HDR_LSB    = 29;
  localparam int WORD_BRIGHT_LSB = 24;
  localparam int WORD_B_LSB      = 16;
  localparam int WORD_G_LSB      = 8;
  localparam int WORD_R_LSB      = 0;

  // Assemble header, global brightness and BGR colour into one LED word.
  function automatic logic [31:0] apa102_word(input logic [4:0]  bright,
                                              input logic [23:0] bgr);
    logic [31:0] word;
    word                          = '0;
    word[WORD_HDR_LSB +: 3]       = APA102_HDR;
    word[WORD_BRIGHT_LSB +: 5]    = bright;
    word[WORD_R_LSB +: 24]        = bgr;
    return word;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dostring_colour.sv
`default_nettype none
// ============================================================================
// Module  : dostring_colour
// Purpose : Combinational colour generator. Maps (pattern mode, LED index,
//           animation head) to a 24-bit BGR colour triple.
// Ports   : mode [1:0]        pattern select (dostring_pkg::mode_t code)
//           idx  [IDX_W-1:0]  LED index within the frame
//           head [IDX_W-1:0]  animation head for this frame
//           bgr  [23:0]       colour out, {B, G, R}
// Notes   : IDX_W must be at least 8 (RAMP takes the low byte of idx+head).
// Rev     : 1.0  initial release
// ============================================================================
module dostring_colour
  import dostring_pkg::*;
#(
  parameter int IDX_W = 8
) (
  input  logic [1:0]       mode,
  input  logic [IDX_W-1:0] idx,
  input  logic [IDX_W-1:0] head,
  output logic [23:0]      bgr
);

  logic [IDX_W-1:0] sum;
  logic [7:0]       r;
  logic [7:0]       g;
  logic [7:0]       b;

  // Wraps modulo 2^IDX_W by construction of the result width.
  assign sum = idx + head;

  always_comb begin
    r = 8'h00;
    g = 8'h00;
    b = 8'h00;
    case (mode_t'(mode))
      MODE_CHASE: r = (idx == head) ? 8'hFF : 8'h00;
      MODE_SOLID: begin
        r = 8'hFF;
        g = 8'hFF;
        b = 8'hFF;
      end
      MODE_RAMP: begin
        r = sum[7:0];
        g = ~sum[7:0];
      end
      default: ;  // MODE_OFF: black
    endcase

    bgr                   = '0;
    bgr[WORD_B_LSB +: 8]  = b;
    bgr[WORD_G_LSB +: 8]  = g;
    bgr[WORD_R_LSB +: 8]  = r;
  end

endmodule
`default_nettype wire

// File: rtl/dostring_pattern.sv
`default_nettype none
// ============================================================================
// Module  : dostring_pattern
// Purpose : Frame-based pixel source feeding the LED-string serializer.
//           Emits NUM_LEDS APA102 words per frame over a valid/ready stream,
//           idles FRAME_GAP cycles between frames and advances an animation
//           head once per frame.
// Ports   : pattern_clk        block clock (divided local clock)
//           pattern_reset      asynchronous active-low reset
//           enable             run request (level)
//           mode [1:0]         pattern select, latched at frame start
//           pix_ready          downstream accepts pix_data this cycle
//           pix_valid          pix_data valid
//           pix_data [31:0]    LED word {3'b111, BRIGHT, B, G, R}
//           pix_first          word is LED 0
//           pix_last           word is LED NUM_LEDS-1
//           frame_count [15:0] completed frames (wraps)
//           busy               state is not IDLE
// Rev     : 1.0  initial release
// ============================================================================
module dostring_pattern
  import dostring_pkg::*;
#(
  parameter int         NUM_LEDS  = 60,
  parameter int         IDX_W     = 8,
  parameter logic [4:0] BRIGHT    = 5'd31,
  parameter int         FRAME_GAP = 1000
) (
  input  logic        pattern_clk,
  input  logic        pattern_reset,
  input  logic        enable,
  input  logic [1:0]  mode,
  input  logic        pix_ready,
  output logic        pix_valid,
  output logic [31:0] pix_data,
  output logic        pix_first,
  output logic        pix_last,
  output logic [15:0] frame_count,
  output logic        busy
);

  // Gap counter only needs to reach FRAME_GAP-1.
  localparam int               GAP_W    = (FRAME_GAP > 1) ? $clog2(FRAME_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_END  = GAP_W'(FRAME_GAP - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LEDS - 1);

  state_t           state;
  logic [1:0]       mode_q;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] head;
  logic [GAP_W-1:0] gap_cnt;

  logic [1:0]       col_mode;
  logic [IDX_W-1:0] col_idx;
  logic [IDX_W-1:0] idx_inc;
  logic [23:0]      col_bgr;
  logic [31:0]      next_word;

  assign idx_inc = idx + IDX_W'(1);

  // The colour unit always looks one word ahead: in EMIT it prepares the
  // word after the one on the bus; elsewhere it prepares LED 0 using the
  // live mode input, which is what gets latched at the frame-start edge.
  assign col_mode = (state == ST_EMIT) ? mode_q  : mode;
  assign col_idx  = (state == ST_EMIT) ? idx_inc : '0;

  dostring_colour #(
    .IDX_W (IDX_W)
  ) u_colour (
    .mode (col_mode),
    .idx  (col_idx),
    .head (head),
    .bgr  (col_bgr)
  );

  assign next_word = apa102_word(BRIGHT, col_bgr);
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge pattern_clk or negedge pattern_reset) begin
    if (!pattern_reset) begin
      state       <= ST_IDLE;
      mode_q      <= '0;
      idx         <= '0;
      head        <= '0;
      gap_cnt     <= '0;
      pix_valid   <= 1'b0;
      pix_data    <= '0;
      pix_first   <= 1'b0;
      pix_last    <= 1'b0;
      frame_count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (enable) begin
            state     <= ST_EMIT;
            mode_q    <= mode;
            idx       <= '0;
            pix_valid <= 1'b1;
            pix_data  <= next_word;
            pix_first <= 1'b1;
            pix_last  <= 1'b0;
          end
        end

        ST_EMIT: begin
          if (pix_valid && pix_ready) begin
            if (idx != LAST_IDX) begin
              idx       <= idx_inc;
              pix_data  <= next_word;
              pix_first <= 1'b0;
              pix_last  <= (idx_inc == LAST_IDX);
            end else begin
              state       <= ST_GAP;
              pix_valid   <= 1'b0;
              pix_first   <= 1'b0;
              pix_last    <= 1'b0;
              frame_count <= frame_count + 16'd1;
              head        <= (head == LAST_IDX) ? '0 : head + IDX_W'(1);
              gap_cnt     <= '0;
            end
          end
        end

        ST_GAP: begin
          if (gap_cnt == GAP_END) begin
            if (enable) begin
              state     <= ST_EMIT;
              mode_q    <= mode;
              idx       <= '0;
              pix_valid <= 1'b1;
              pix_data  <= next_word;
              pix_first <= 1'b1;
              pix_last  <= 1'b0;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/dostring_pattern.md
Name: dostring_pattern

Overview:
- Pixel source directly upstream of the LED-string serializer (dostring_wave).
- Generates one frame of NUM_LEDS APA102-format LED words per refresh and presents them over a valid/ready stream.
- Inserts a programmable inter-frame gap and advances an animation head each frame.
- Runs on the same divided local clock as the serializer.

Parameters:
- NUM_LEDS, 60: LEDs per frame; must be 2..255.
- IDX_W, 8: width of the LED index and head counters.
- BRIGHT, 5'd31: APA102 global-brightness field placed in every word.
- FRAME_GAP, 1000: idle cycles between frames; must be >= 1.

Ports:
- pattern_clk  input  1  block clock (divided local clock).
- pattern_reset  input  1  asynchronous, active-low reset.
- enable  input  1  run request, level-sensitive.
- mode  input  2  pattern select; latched at frame start.
- pix_ready  input  1  serializer can accept pix_data this cycle.
- pix_valid  output  1  pix_data is valid.
- pix_data  output  32  LED word: [31:29]=3'b111, [28:24]=BRIGHT, [23:16]=B, [15:8]=G, [7:0]=R.
- pix_first  output  1  current word is LED 0 of the frame.
- pix_last  output  1  current word is LED NUM_LEDS-1.
- frame_count  output  16  number of completed frames; wraps.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Clock and reset: one clock, pattern_clk. Reset is asynchronous and active-low.
- Reset values: state=IDLE; pix_valid=0; pix_data=0; pix_first=0; pix_last=0; frame_count=0; busy=0; idx=0; head=0; gap counter=0.
- Handshake: a transfer occurs when pix_valid && pix_ready.
  - While pix_valid=1 && pix_ready=0, pix_data/pix_first/pix_last hold stable.
  - pix_valid never drops without a transfer.
  - pix_valid does not depend combinationally on pix_ready.
- States:
  - IDLE: enable=1 sampled -> EMIT next cycle. That clock edge latches mode into mode_q, sets idx=0, and loads the word for LED 0. pix_valid rises 1 cycle after enable is first sampled high.
  - EMIT: on each transfer with idx<NUM_LEDS-1, increment idx and load the next word in the same edge, so back-to-back transfers sustain 1 word/cycle.
  - EMIT, transfer at idx=NUM_LEDS-1: pix_valid=0; frame_count+1; head=(head==NUM_LEDS-1)?0:head+1; gap counter=0; go to GAP.
  - GAP: count exactly FRAME_GAP cycles, then go to EMIT if enable=1 (new frame, mode re-latched) or IDLE if enable=0.
- enable=0 mid-frame: the current frame completes in full; the gap still runs; then IDLE.
- mode changes mid-frame are ignored until the next frame start.
- pix_first = (idx==0) while valid. pix_last = (idx==NUM_LEDS-1) while valid.
- Colour per LED i, head h, from mode_q:
  - 0 CHASE: R=8'hFF if i==h, else R=0. G=B=0.
  - 1 SOLID: R=G=B=8'hFF.
  - 2 RAMP: s=(i+h) computed as an IDX_W-bit sum, wrapping. R=s[7:0], G=~s[7:0], B=0.
  - 3 OFF: R=G=B=0; header and brightness still emitted.
- Arithmetic: all index sums wrap modulo 2^IDX_W; no saturation. frame_count wraps 16'hFFFF->0.
- Reset asserted mid-frame: immediate return to the reset values; no partial-frame completion.

Decomposition:
- Shared package/header dostring_pkg:
  - mode constants MODE_CHASE=0, MODE_SOLID=1, MODE_RAMP=2, MODE_OFF=3;
  - APA102_HDR=3'b111;
  - state encodings IDLE/EMIT/GAP;
  - word field offsets.
  These are shared with dostring_wave and future pattern blocks.
- One natural sub-module: dostring_colour, purely combinational (mode_q, idx, head -> 24-bit BGR). It gets its own unit test and is reused by later pattern blocks.

Test Plan:
- Reset, then enable=1, mode=1, pix_ready=1 -> pix_valid rises 1 cycle after enable. 60 consecutive words of 32'hFFFFFFFF. pix_first on word 0, pix_last on word 59. frame_count 0->1.
- mode=0 over 3 frames, NUM_LEDS=60 -> nonzero word is 32'hFF0000FF at LED 0, then LED 1, then LED 2. head wraps 59->0 on frame 61.
- Backpressure: pix_ready toggled pseudo-randomly -> pix_data stable while stalled. No word lost or duplicated; sequence identical to the pix_ready=1 run.
- Gap timing with FRAME_GAP=5 -> exactly 5 cycles of pix_valid=0 between the last transfer and the next pix_first.
- mode switched 2->3 at LED 30, then enable=0 at LED 40 -> rest of the frame stays RAMP (e.g. LED 40, h=0: 32'hFF00D728). The frame completes, then the gap, then IDLE with busy=0.
- pattern_reset pulsed low at LED 17 -> all outputs return to reset values asynchronously. The next enable restarts at LED 0 with head=0 and frame_count=0.
